// File: rtl/oddrx2_pkg.sv
// Shared types and helpers for the ODDRX2F 4:1 transmit lane.
// State encoding for the lane bring-up sequencer and the nibble width.
package oddrx2_pkg;

   localparam int NIB = 4;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_HOLD,
      ST_STOP,
      ST_SETTLE,
      ST_RUN
   } state_e;

   // Counter width that never collapses to zero bits.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/oddrx2_oe_delay.sv
// Output-enable delay line for the ODDRX2F lane.
// Shifts oe_i by OE_LAT SCLK cycles so TX_OE lines up with Q.
module oddrx2_oe_delay
   import oddrx2_pkg::*;
#(
   parameter int OE_LAT = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic oe_i,
   output logic oe_o
);

   if (OE_LAT == 0) begin : g_thru

      assign oe_o = oe_i;

   end else if (OE_LAT == 1) begin : g_one

      logic line_q;

      // Single stage of delay, cleared by reset.
      always_ff @(posedge clk_i) begin
         if (rst_i) line_q <= 1'b0;
         else       line_q <= oe_i;
      end

      assign oe_o = line_q;

   end else begin : g_line

      logic [OE_LAT-1:0] line_q;

      // Shift oe_i in at bit 0; the oldest sample leaves at the top.
      always_ff @(posedge clk_i) begin
         if (rst_i) line_q <= '0;
         else       line_q <= {line_q[OE_LAT-2:0], oe_i};
      end

      assign oe_o = line_q[OE_LAT-1];

   end

endmodule

// File: rtl/oddrx2_tx_sequencer.sv
// ODDRX2F lane controller: bring-up sequencing and word-to-nibble gearbox.
// Everything runs on SCLK; outputs are registered except IN_READY.
module oddrx2_tx_sequencer
   import oddrx2_pkg::*;
#(
   parameter int          WIDTH         = 16,
   parameter int          RST_CYCLES    = 4,
   parameter int          STOP_CYCLES   = 2,
   parameter int          SETTLE_CYCLES = 4,
   parameter logic [3:0]  IDLE_NIBBLE   = 4'h0,
   parameter int          OE_LAT        = 3
) (
   input  logic             SCLK,
   input  logic             RST,
   input  logic             EN,
   input  logic [WIDTH-1:0] IN_DATA,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic             D0,
   output logic             D1,
   output logic             D2,
   output logic             D3,
   output logic             ODDR_RST,
   output logic             ECLK_STOP,
   output logic             TX_OE,
   output logic             LINK_UP
);

   localparam int MAXA = (RST_CYCLES > STOP_CYCLES) ?
                         RST_CYCLES : STOP_CYCLES;
   localparam int MAXC = (MAXA > SETTLE_CYCLES) ?
                         MAXA : SETTLE_CYCLES;
   localparam int CW   = clog2_min1(MAXC);
   localparam int NNIB = WIDTH / NIB;
   localparam int NW   = clog2_min1(NNIB);

   localparam logic [CW-1:0] RST_LD    = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] STOP_LD   = CW'(STOP_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
   localparam logic [NW-1:0] LAST_NIB  = NW'(NNIB - 1);

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            odrst_q;
   logic            stop_q;
   logic            link_q;

   logic [WIDTH-1:0] sh_q, sh_d;
   logic [NW-1:0]    nib_q, nib_d;
   logic             busy_q, busy_d;
   logic [3:0]       d_q, d_d;

   logic             in_ready;
   logic             accept;
   logic             last_nib;

   // Bring-up sequencer with registered lane-control outputs.
   always_ff @(posedge SCLK) begin
      if (RST || !EN) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         odrst_q <= 1'b1;
         stop_q  <= 1'b0;
         link_q  <= 1'b0;
      end else begin
         unique case (state_q)
            ST_OFF: begin
               state_q <= ST_HOLD;
               cnt_q   <= RST_LD;
               odrst_q <= 1'b1;
            end
            ST_HOLD: begin
               if (cnt_q == '0) begin
                  state_q <= ST_STOP;
                  cnt_q   <= STOP_LD;
                  stop_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_STOP: begin
               if (cnt_q == '0) begin
                  state_q <= ST_SETTLE;
                  cnt_q   <= SETTLE_LD;
                  stop_q  <= 1'b0;
                  odrst_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_SETTLE: begin
               if (cnt_q == '0) begin
                  state_q <= ST_RUN;
                  link_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_RUN: begin
               link_q <= 1'b1;
            end
            default: begin
               state_q <= ST_OFF;
               cnt_q   <= '0;
               odrst_q <= 1'b1;
               stop_q  <= 1'b0;
               link_q  <= 1'b0;
            end
         endcase
      end
   end

   assign last_nib = (nib_q == LAST_NIB);
   assign in_ready = !RST && EN && (state_q == ST_RUN) &&
                     (!busy_q || last_nib);
   assign accept   = in_ready && IN_VALID;

   // Gearbox: load on accept, otherwise step through the word.
   always_comb begin
      sh_d   = sh_q;
      nib_d  = nib_q;
      busy_d = busy_q;
      d_d    = d_q;
      if (!EN || state_q != ST_RUN) begin
         sh_d   = '0;
         nib_d  = '0;
         busy_d = 1'b0;
         d_d    = IDLE_NIBBLE;
      end else if (accept) begin
         d_d    = IN_DATA[NIB-1:0];
         sh_d   = IN_DATA >> NIB;
         nib_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q && !last_nib) begin
         d_d    = sh_q[NIB-1:0];
         sh_d   = sh_q >> NIB;
         nib_d  = nib_q + 1'b1;
      end else begin
         sh_d   = '0;
         nib_d  = '0;
         busy_d = 1'b0;
         d_d    = IDLE_NIBBLE;
      end
   end

   // Gearbox state and the registered nibble on D0..D3.
   always_ff @(posedge SCLK) begin
      if (RST) begin
         sh_q   <= '0;
         nib_q  <= '0;
         busy_q <= 1'b0;
         d_q    <= IDLE_NIBBLE;
      end else begin
         sh_q   <= sh_d;
         nib_q  <= nib_d;
         busy_q <= busy_d;
         d_q    <= d_d;
      end
   end

   // busy_q is high exactly while a data nibble sits on D.
   oddrx2_oe_delay #(
      .OE_LAT (OE_LAT)
   ) u_oe_delay (
      .clk_i (SCLK),
      .rst_i (RST),
      .oe_i  (busy_q),
      .oe_o  (TX_OE)
   );

   assign IN_READY          = in_ready;
   assign {D3, D2, D1, D0}  = d_q;
   assign ODDR_RST          = odrst_q;
   assign ECLK_STOP         = stop_q;
   assign LINK_UP           = link_q;

endmodule

// File: tb/tb_oddrx2_tx_sequencer.sv
// Scoreboard bench for the ODDRX2F lane controller.
// Driver pushes expected nibbles/OE cycles; a monitor pops and compares.
module tb_oddrx2_tx_sequencer;

   logic        SCLK = 1'b0;
   logic        RST;
   logic        EN;
   logic [15:0] IN_DATA;
   logic        IN_VALID;
   logic        IN_READY;
   logic        D0, D1, D2, D3;
   logic        ODDR_RST;
   logic        ECLK_STOP;
   logic        TX_OE;
   logic        LINK_UP;

   oddrx2_tx_sequencer #(
      .WIDTH         (16),
      .RST_CYCLES    (4),
      .STOP_CYCLES   (2),
      .SETTLE_CYCLES (4),
      .IDLE_NIBBLE   (4'h0),
      .OE_LAT        (3)
   ) dut (
      .SCLK      (SCLK),
      .RST       (RST),
      .EN        (EN),
      .IN_DATA   (IN_DATA),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .D0        (D0),
      .D1        (D1),
      .D2        (D2),
      .D3        (D3),
      .ODDR_RST  (ODDR_RST),
      .ECLK_STOP (ECLK_STOP),
      .TX_OE     (TX_OE),
      .LINK_UP   (LINK_UP)
   );

   always #5 SCLK = ~SCLK;

   typedef struct {
      int         c;
      logic [3:0] n;
   } ent_t;

   ent_t dq[$];
   int   oq[$];
   int   cyc    = 0;
   bit   mon_en = 1'b0;
   int   errs   = 0;
   int   checks = 0;
   int   w;

   logic [3:0] exp_n;
   logic       exp_o;

   always @(posedge SCLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Monitor: every cycle compare D and TX_OE against the scoreboard.
   always @(negedge SCLK) begin
      if (mon_en) begin
         while (dq.size() > 0 && dq[0].c < cyc) begin
            checks++;
            errs++;
            $display("FAIL d_stale: nibble %0h due cycle %0d never seen",
                     dq[0].n, dq[0].c);
            void'(dq.pop_front());
         end
         while (oq.size() > 0 && oq[0] < cyc) begin
            checks++;
            errs++;
            $display("FAIL oe_stale: oe due cycle %0d never seen", oq[0]);
            void'(oq.pop_front());
         end
         exp_n = 4'h0;
         if (dq.size() > 0 && dq[0].c == cyc) begin
            exp_n = dq[0].n;
            void'(dq.pop_front());
         end
         chk("mon_d", {D3, D2, D1, D0}, exp_n);
         exp_o = 1'b0;
         if (oq.size() > 0 && oq[0] == cyc) begin
            exp_o = 1'b1;
            void'(oq.pop_front());
         end
         chk("mon_tx_oe", TX_OE, exp_o);
      end
   end

   // Offer a word at a negedge, wait for accept, schedule its nibbles.
   task automatic send(input logic [15:0] wd, input logic [15:0] exp,
                       output int waited);
      int   n;
      ent_t e;
      n        = 0;
      IN_DATA  = wd;
      IN_VALID = 1'b1;
      #1;
      while (IN_READY !== 1'b1 && n < 20) begin
         @(negedge SCLK);
         #1;
         n++;
      end
      waited = n;
      if (IN_READY !== 1'b1) begin
         checks++;
         errs++;
         $display("FAIL send_timeout: word %0h not accepted", wd);
      end else begin
         for (int i = 0; i < 4; i++) begin
            e.c = cyc + 1 + i;
            e.n = exp[15-4*i -: 4];
            dq.push_back(e);
            oq.push_back(cyc + 4 + i);
         end
      end
      @(negedge SCLK);
   endtask

   task automatic flush(input int k, input bit all_oe);
      while (dq.size() > 0 && dq[$].c > k) void'(dq.pop_back());
      while (oq.size() > 0 && oq[$] > (all_oe ? k : k + 3))
         void'(oq.pop_back());
   endtask

   // EN rises with IN_VALID held; walk the hand table of bring-up.
   task automatic bringup();
      EN       = 1'b1;
      IN_VALID = 1'b1;
      IN_DATA  = 16'hFFFF;
      for (int i = 1; i <= 11; i++) begin
         @(negedge SCLK);
         #1;
         chk("bu_oddr_rst", ODDR_RST, (i <= 6));
         chk("bu_eclk_stop", ECLK_STOP, (i >= 5 && i <= 6));
         chk("bu_link_up", LINK_UP, (i >= 11));
         chk("bu_in_ready", IN_READY, (i >= 11));
         if (i == 10) IN_VALID = 1'b0;
      end
   endtask

   initial begin
      RST      = 1'b1;
      EN       = 1'b0;
      IN_VALID = 1'b0;
      IN_DATA  = '0;
      repeat (2) @(negedge SCLK);
      chk("rst_oddr_rst", ODDR_RST, 1);
      chk("rst_eclk_stop", ECLK_STOP, 0);
      chk("rst_link_up", LINK_UP, 0);
      chk("rst_tx_oe", TX_OE, 0);
      chk("rst_in_ready", IN_READY, 0);
      chk("rst_d", {D3, D2, D1, D0}, 4'h0);
      mon_en = 1'b1;
      RST    = 1'b0;
      @(negedge SCLK);
      chk("off_oddr_rst", ODDR_RST, 1);

      bringup();

      send(16'hA5C3, 16'h3C5A, w);
      chk("single_wait", w, 0);
      IN_VALID = 1'b0;
      repeat (10) @(negedge SCLK);

      send(16'h1234, 16'h4321, w);
      chk("b2b_first_wait", w, 0);
      send(16'h5678, 16'h8765, w);
      chk("b2b_ready_on_last", w, 3);
      IN_VALID = 1'b0;
      repeat (10) @(negedge SCLK);

      send(16'h9ABC, 16'hCBA9, w);
      @(negedge SCLK);
      EN       = 1'b0;
      IN_VALID = 1'b1;
      IN_DATA  = 16'h7777;
      flush(cyc, 1'b0);
      #1;
      chk("endrop_in_ready", IN_READY, 0);
      @(negedge SCLK);
      chk("endrop_oddr_rst", ODDR_RST, 1);
      chk("endrop_link_up", LINK_UP, 0);
      chk("endrop_eclk_stop", ECLK_STOP, 0);
      bringup();

      send(16'hDEAD, 16'hDAED, w);
      @(negedge SCLK);
      RST      = 1'b1;
      EN       = 1'b0;
      IN_VALID = 1'b1;
      IN_DATA  = 16'h5555;
      flush(cyc, 1'b1);
      #1;
      chk("rstrun_in_ready", IN_READY, 0);
      @(negedge SCLK);
      chk("rstrun_oddr_rst", ODDR_RST, 1);
      chk("rstrun_link_up", LINK_UP, 0);
      chk("rstrun_tx_oe", TX_OE, 0);
      @(negedge SCLK);
      chk("rstrun_in_ready_hold", IN_READY, 0);
      RST      = 1'b0;
      IN_VALID = 1'b0;
      bringup();

      send(16'hBEEF, 16'hFEEB, w);
      chk("after_rst_wait", w, 0);
      IN_VALID = 1'b0;
      repeat (10) @(negedge SCLK);

      chk("d_queue_drained", dq.size(), 0);
      chk("oe_queue_drained", oq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
